// File: rtl/ttd_sequencer.sv
// Time-to-digital capacitor sequencer: discharge, timed charge, average 2^NSAMPLES_LOG2 samples.
// Result appears the cycle after the data_valid pulse; no backpressure, abort cancels a batch.
module ttd_sequencer #(
    parameter int TIMER_BITS       = 8,
    parameter int PRESCALE         = 4,
    parameter int DISCHARGE_CYCLES = 16,
    parameter int NSAMPLES_LOG2    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  continuous,
    input  logic                  abort,
    input  logic                  cmp_in,
    output logic                  rst_cap,
    output logic                  busy,
    output logic [TIMER_BITS-1:0] data_out,
    output logic                  data_valid,
    output logic                  timeout
);

    localparam int ACC_W = TIMER_BITS + NSAMPLES_LOG2;
    localparam int IDX_W = (NSAMPLES_LOG2 > 0) ? NSAMPLES_LOG2 : 1;
    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DC_W  = (DISCHARGE_CYCLES > 1) ? $clog2(DISCHARGE_CYCLES) : 1;

    localparam logic [TIMER_BITS-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'((1 << NSAMPLES_LOG2) - 1);
    localparam logic [PS_W-1:0]       PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [DC_W-1:0]       DC_LAST  = DC_W'(DISCHARGE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DISCHARGE,
        CHARGE,
        ACCUM,
        DONE
    } state_t;

    state_t                state, state_nxt;
    logic                  cmp_meta, cmp_s;
    logic [DC_W-1:0]       dis_cnt;
    logic [PS_W-1:0]       prescale;
    logic [TIMER_BITS-1:0] count;
    logic [TIMER_BITS-1:0] sample;
    logic [ACC_W-1:0]      acc;
    logic [IDX_W-1:0]      idx;
    logic                  batch_to;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_meta <= 1'b0;
            cmp_s    <= 1'b0;
        end else begin
            cmp_meta <= cmp_in;
            cmp_s    <= cmp_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start) state_nxt = DISCHARGE;
            DISCHARGE: if (dis_cnt == DC_LAST) state_nxt = CHARGE;
            CHARGE:    if (cmp_s || count == CNT_MAX) state_nxt = ACCUM;
            ACCUM:     state_nxt = (idx == IDX_LAST) ? DONE : DISCHARGE;
            DONE:      state_nxt = continuous ? DISCHARGE : IDLE;
            default:   state_nxt = IDLE;
        endcase
        if (abort && state != IDLE) state_nxt = IDLE;
    end

    assign rst_cap    = (state != CHARGE);
    assign busy       = (state != IDLE);
    assign data_valid = (state == DONE) && !abort;

    // Prescaler and counter idle at zero outside CHARGE, so every charge phase starts from k=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dis_cnt  <= '0;
            prescale <= '0;
            count    <= '0;
            sample   <= '0;
        end else begin
            dis_cnt <= (state == DISCHARGE) ? dis_cnt + DC_W'(1) : '0;
            if (state != CHARGE) begin
                prescale <= '0;
                count    <= '0;
            end else begin
                sample <= count;
                if (prescale == PS_LAST) begin
                    prescale <= '0;
                    if (count != CNT_MAX) count <= count + TIMER_BITS'(1);
                end else begin
                    prescale <= prescale + PS_W'(1);
                end
            end
        end
    end

    // Batch state is cleared in IDLE and DONE; DONE reads the old values before they clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            idx      <= '0;
            batch_to <= 1'b0;
            data_out <= '0;
            timeout  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    acc      <= '0;
                    idx      <= '0;
                    batch_to <= 1'b0;
                end
                CHARGE: begin
                    if (!cmp_s && count == CNT_MAX) batch_to <= 1'b1;
                end
                ACCUM: begin
                    acc <= acc + ACC_W'(sample);
                    if (idx != IDX_LAST) idx <= idx + IDX_W'(1);
                end
                default: ;
            endcase
            if (state == DONE && !abort) begin
                data_out <= TIMER_BITS'(acc >> NSAMPLES_LOG2);
                timeout  <= batch_to;
            end
        end
    end

endmodule

// File: tb/tb_ttd_sequencer.sv
// Bench for ttd_sequencer: a comparator model raises cmp_in a programmed delay after each
// charge entry; batch results go through a scoreboard queue, plus abort/continuous/reset cases.
`timescale 1ns/1ps
module tb_ttd_sequencer;

    logic       clk, rst_n, start, continuous, abort, cmp_in;
    logic       rst_cap, busy, data_valid, timeout;
    logic [7:0] data_out;

    ttd_sequencer #(
        .TIMER_BITS(8), .PRESCALE(4), .DISCHARGE_CYCLES(16), .NSAMPLES_LOG2(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .abort(abort),
        .cmp_in(cmp_in), .rst_cap(rst_cap), .busy(busy), .data_out(data_out),
        .data_valid(data_valid), .timeout(timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [7:0] dat;
        logic       to;
    } res_t;

    typedef struct {
        int         d0, d1, d2, d3;
        logic [7:0] dat;
        logic       to;
    } vec_t;

    res_t exp_q[$];
    int   dly_tab[4];
    int   samp_i;
    int   n_chk, n_err, n_dv;
    bit   len_chk;
    logic [7:0] last_dat;
    logic       last_to;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Comparator model (-1 = never crosses) and charge-phase length check.
    initial begin : cmp_drv
        int  cnt, len, exp_len, cur;
        bit  prev, armed;
        cmp_in = 1'b0; prev = 1'b1; armed = 1'b0; cnt = 0; len = 0; exp_len = 0; cur = 0;
        forever begin
            @(negedge clk);
            if (rst_cap) begin
                if (!prev && len_chk) chk("charge_len", len, exp_len);
                cmp_in = 1'b0;
                armed  = 1'b0;
            end else if (prev) begin
                cur = dly_tab[samp_i % 4];
                samp_i++;
                armed   = (cur > 0);
                cnt     = cur;
                len     = 1;
                exp_len = (cur < 0) ? 1021 : (((cur + 2) > 1020) ? 1020 : cur + 2) + 1;
            end else begin
                len++;
                if (armed) begin
                    cnt--;
                    if (cnt == 0) begin
                        cmp_in = 1'b1;
                        armed  = 1'b0;
                    end
                end
            end
            prev = rst_cap;
        end
    end

    // Result monitor: data_out/timeout are checked the cycle after data_valid.
    initial begin : mon
        bit   c;
        res_t e;
        forever begin
            @(negedge clk);
            if (data_valid === 1'b1) begin
                n_dv++;
                c = continuous;
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_dv: data_valid with empty scoreboard, data_out=%0d", data_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("data_out", int'(data_out), int'(e.dat));
                    chk("timeout", int'(timeout), int'(e.to));
                end
                chk("busy_after_done", int'(busy), int'(c));
                chk("rst_cap_after_done", int'(rst_cap), 1);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget && busy; i++) @(negedge clk);
        if (busy) begin
            n_chk++;
            n_err++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles", budget);
        end
    endtask

    task automatic wait_charge(input int nth, output bit found);
        bit prev_rc;
        int seen;
        prev_rc = 1'b1; seen = 0; found = 1'b0;
        for (int i = 0; i < 6000 && !found; i++) begin
            @(negedge clk);
            if (!rst_cap && prev_rc) begin
                seen++;
                if (seen == nth) found = 1'b1;
            end
            prev_rc = rst_cap;
        end
        if (!found) begin
            n_chk++;
            n_err++;
            $display("FAIL wait_charge: charge entry %0d not seen", nth);
        end
    endtask

    task automatic set_dly(input int a, input int b, input int c, input int d);
        dly_tab[0] = a; dly_tab[1] = b; dly_tab[2] = c; dly_tab[3] = d;
        samp_i = 0;
    endtask

    initial begin : watchdog
        #(90000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err + 1);
        $fatal(1);
    end

    initial begin : main
        vec_t tab[8];
        int   dv0;
        bit   found;

        n_chk = 0; n_err = 0; n_dv = 0; len_chk = 1'b1;
        start = 1'b0; continuous = 1'b0; abort = 1'b0; rst_n = 1'b0;
        set_dly(398, 398, 398, 398);
        last_dat = 8'd0; last_to = 1'b0;

        tab[0] = '{398, 398, 398, 398, 8'd100, 1'b0};
        tab[1] = '{-1, -1, -1, -1, 8'd255, 1'b1};
        tab[2] = '{398, 398, 398, 410, 8'd100, 1'b0};
        tab[3] = '{1, 1, 1, 1, 8'd0, 1'b0};
        tab[4] = '{2, 6, 10, 14, 8'd2, 1'b0};
        tab[5] = '{398, -1, 398, 398, 8'd138, 1'b1};
        tab[6] = '{1017, 1017, 1017, 1017, 8'd254, 1'b0};
        tab[7] = '{1018, 1018, 1018, 1018, 8'd255, 1'b0};

        #2;
        chk("rst_rst_cap", int'(rst_cap), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_data_valid", int'(data_valid), 0);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_timeout", int'(timeout), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_rst_cap", int'(rst_cap), 1);

        for (int v = 0; v < 8; v++) begin
            set_dly(tab[v].d0, tab[v].d1, tab[v].d2, tab[v].d3);
            exp_q.push_back('{tab[v].dat, tab[v].to});
            last_dat = tab[v].dat;
            last_to  = tab[v].to;
            dv0 = n_dv;
            pulse_start();
            chk("busy_after_start", int'(busy), 1);
            repeat (30) @(negedge clk);
            pulse_start();
            wait_idle(6000);
            @(negedge clk);
            chk("dv_count", n_dv - dv0, 1);
            chk("busy_end", int'(busy), 0);
        end

        // Abort at CHARGE cycle 200 of the third sample.
        set_dly(398, 398, 398, 398);
        len_chk = 1'b0;
        dv0 = n_dv;
        pulse_start();
        wait_charge(3, found);
        if (found) begin
            repeat (200) @(negedge clk);
            chk("abort_pre_rst_cap", int'(rst_cap), 0);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk("abort_rst_cap", int'(rst_cap), 1);
            chk("abort_busy", int'(busy), 0);
        end
        repeat (40) @(negedge clk);
        chk("abort_no_dv", n_dv - dv0, 0);
        chk("abort_data_out", int'(data_out), int'(last_dat));
        chk("abort_timeout", int'(timeout), int'(last_to));
        len_chk = 1'b1;

        // Continuous: three batches back to back, then stop after the current one.
        set_dly(398, 398, 398, 398);
        for (int i = 0; i < 3; i++) exp_q.push_back('{8'd100, 1'b0});
        continuous = 1'b1;
        dv0 = n_dv;
        pulse_start();
        for (int i = 0; i < 5000 && (n_dv - dv0) < 2; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        continuous = 1'b0;
        wait_idle(3000);
        repeat (3) @(negedge clk);
        chk("cont_dv_count", n_dv - dv0, 3);

        // Reset mid-CHARGE: outputs must return to reset values before the next edge.
        set_dly(398, 398, 398, 398);
        len_chk = 1'b0;
        pulse_start();
        wait_charge(1, found);
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rst_cap", int'(rst_cap), 1);
        chk("arst_busy", int'(busy), 0);
        chk("arst_data_valid", int'(data_valid), 0);
        chk("arst_data_out", int'(data_out), 0);
        chk("arst_timeout", int'(timeout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        len_chk = 1'b1;
        set_dly(398, 398, 398, 410);
        exp_q.push_back('{8'd100, 1'b0});
        dv0 = n_dv;
        pulse_start();
        wait_idle(6000);
        @(negedge clk);
        chk("post_rst_dv_count", n_dv - dv0, 1);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ttd_sequencer.md
TTD_SEQUENCER -- requirements
Module: ttd_sequencer

Interface
REQ-001 Parameter TIMER_BITS, default 8: width of the per-sample charge-time count and of data_out.
REQ-002 Parameter PRESCALE, default 4: clk cycles per count increment during CHARGE (>=1).
REQ-003 Parameter DISCHARGE_CYCLES, default 16: cycles rst_cap is held high before each charge phase (>=1).
REQ-004 Parameter NSAMPLES_LOG2, default 2: log2 of samples averaged per result (0..4).
REQ-005 clk  input  1  single system clock, rising-edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  level-sampled request to begin a measurement batch.
REQ-008 continuous  input  1  when high, a new batch begins immediately after each result.
REQ-009 abort  input  1  synchronous cancel of any batch in progress.
REQ-010 cmp_in  input  1  asynchronous comparator output, high once the capacitor crosses threshold.
REQ-011 rst_cap  output  1  capacitor discharge control, high = discharge.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 data_out  output  TIMER_BITS  averaged charge-time count of the last completed batch.
REQ-014 data_valid  output  1  single-cycle pulse when data_out updates.
REQ-015 timeout  output  1  set with data_valid if any sample of that batch timed out; held with data_out.

Function
REQ-016 cmp_in SHALL pass through a 2-FF synchronizer (cmp_s); only cmp_s is used by the FSM.
REQ-017 States: IDLE, DISCHARGE, CHARGE, ACCUM, DONE; rst_cap = 1 in all states except CHARGE.
REQ-018 IDLE: start=1 -> DISCHARGE; clear accumulator, sample index, and batch timeout flag.
REQ-019 DISCHARGE: stay exactly DISCHARGE_CYCLES cycles, then -> CHARGE with prescaler and counter cleared.
REQ-020 CHARGE: counter value at CHARGE cycle k (k=0 first) SHALL equal floor(k/PRESCALE), saturating at 2^TIMER_BITS-1.
REQ-021 CHARGE: first cycle cmp_s=1 -> sample = current counter value, -> ACCUM.
REQ-022 CHARGE: counter = 2^TIMER_BITS-1 with cmp_s=0 -> sample = 2^TIMER_BITS-1, set batch timeout flag, -> ACCUM.
REQ-023 cmp_s already high at CHARGE k=0 -> sample = 0, no timeout.
REQ-024 ACCUM: one cycle; accumulator (TIMER_BITS+NSAMPLES_LOG2 bits, no overflow) += sample; if index = 2^NSAMPLES_LOG2-1 -> DONE, else index+1 -> DISCHARGE.
REQ-025 DONE: one cycle; data_out <= accumulator >> NSAMPLES_LOG2 (floor); timeout <= batch flag; data_valid=1 this cycle only.
REQ-026 DONE exit: continuous=1 -> DISCHARGE (fresh batch, accumulator/index/flag cleared); else -> IDLE.
REQ-027 start while busy SHALL be ignored; start held high in IDLE after DONE restarts one cycle later.
REQ-028 abort=1 in any non-IDLE state -> IDLE next cycle, no data_valid, data_out/timeout unchanged; abort has priority over all transitions, including DONE.
REQ-029 data_out and timeout SHALL hold their value between data_valid pulses.

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, rst_cap=1, busy=0, data_valid=0, data_out=0, timeout=0, accumulator/index/prescaler/counter/synchronizer=0.
REQ-031 Reset asserted mid-CHARGE SHALL raise rst_cap without waiting for a clock edge; first start after release begins a fresh batch.

Verification (TIMER_BITS=8, PRESCALE=4, DISCHARGE_CYCLES=16, NSAMPLES_LOG2=2; cmp_in driven away from clk edges)
REQ-032 start pulse; cmp_in rises 398 cycles after each CHARGE entry, falls when rst_cap rises -> four CHARGE phases of 16-cycle discharge each, data_valid once, data_out=100 (0x64), timeout=0, busy low afterwards.
REQ-033 cmp_in tied low -> each CHARGE lasts 1021 cycles, data_out=255 (0xFF), timeout=1.
REQ-034 samples 100,100,100,103 (cmp rise at 398,398,398,410) -> data_out=100 (floor of 403/4), timeout=0.
REQ-035 abort at CHARGE cycle 200 of sample 2 -> rst_cap=1 and busy=0 one cycle later, no data_valid, data_out keeps previous value.
REQ-036 continuous=1 with REQ-032 stimulus -> data_valid pulses repeat with DONE immediately followed by DISCHARGE; clearing continuous ends after the current batch.
REQ-037 rst_n low mid-CHARGE -> rst_cap=1 and all outputs at reset values before next clk edge.
